// File: rtl/prbs_burst_sequencer.sv
// rtl/prbs_burst_sequencer.sv - header + PRBS burst sequencer driving an external PRBS15 byte generator
module prbs_burst_sequencer #(
    parameter logic [7:0] HDR_BYTE = 8'hBC,
    parameter int         HDR_LEN  = 4,
    parameter int         GAP_LEN  = 8
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        start,
    input  logic        abort,
    input  logic        loop_en,
    input  logic [15:0] burst_len,
    input  logic [7:0]  gen_data,
    output logic        gen_resetb,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_hdr,
    output logic        tx_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_cnt,
    output logic [15:0] burst_cnt
);

    typedef enum logic [1:0] {IDLE, HEADER, PRBS, GAP} state_t;

    localparam logic [7:0] HDR_LAST = 8'(HDR_LEN);
    localparam logic [7:0] GAP_LAST = 8'(GAP_LEN);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [15:0] len_q, len_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_hdr_q, tx_hdr_d;
    logic        tx_last_q, tx_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        gen_resetb_q, gen_resetb_d;
    logic [15:0] byte_next;

    assign byte_next = byte_cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        tx_data_d    = 8'h00;
        tx_valid_d   = 1'b0;
        tx_hdr_d     = 1'b0;
        tx_last_d    = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        gen_resetb_d = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && burst_len != 16'd0) begin
                    state_d     = HEADER;
                    phase_d     = 8'd1;
                    len_d       = burst_len;
                    byte_cnt_d  = 16'd0;
                    burst_cnt_d = 16'd0;
                    busy_d      = 1'b1;
                    tx_valid_d  = 1'b1;
                    tx_hdr_d    = 1'b1;
                    tx_data_d   = HDR_BYTE;
                end
            end
            HEADER: begin
                if (phase_q == HDR_LAST) begin
                    state_d      = PRBS;
                    tx_valid_d   = 1'b1;
                    tx_last_d    = (len_q == 16'd1);
                    gen_resetb_d = 1'b1;
                end else begin
                    phase_d    = phase_q + 8'd1;
                    tx_valid_d = 1'b1;
                    tx_hdr_d   = 1'b1;
                    tx_data_d  = HDR_BYTE;
                    // Release the generator one cycle early so its pipelined output shows the seed on the first PRBS byte.
                    gen_resetb_d = (phase_q + 8'd1 == HDR_LAST);
                end
            end
            PRBS: begin
                byte_cnt_d = byte_next;
                if (byte_next == len_q) begin
                    done_d      = 1'b1;
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    if (loop_en) begin
                        state_d = GAP;
                        phase_d = 8'd1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    tx_valid_d   = 1'b1;
                    tx_last_d    = ({1'b0, byte_cnt_q} + 17'd2 == {1'b0, len_q});
                    gen_resetb_d = 1'b1;
                end
            end
            GAP: begin
                if (phase_q == GAP_LAST) begin
                    state_d    = HEADER;
                    phase_d    = 8'd1;
                    byte_cnt_d = 16'd0;
                    tx_valid_d = 1'b1;
                    tx_hdr_d   = 1'b1;
                    tx_data_d  = HDR_BYTE;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort still counts a PRBS byte already on the wire this cycle.
        if (abort) begin
            state_d      = IDLE;
            phase_d      = phase_q;
            len_d        = len_q;
            byte_cnt_d   = (state_q == PRBS) ? byte_next : byte_cnt_q;
            burst_cnt_d  = burst_cnt_q;
            tx_data_d    = 8'h00;
            tx_valid_d   = 1'b0;
            tx_hdr_d     = 1'b0;
            tx_last_d    = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            gen_resetb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q      <= IDLE;
            phase_q      <= 8'd0;
            len_q        <= 16'd0;
            byte_cnt_q   <= 16'd0;
            burst_cnt_q  <= 16'd0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_hdr_q     <= 1'b0;
            tx_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            gen_resetb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_hdr_q     <= tx_hdr_d;
            tx_last_q    <= tx_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            gen_resetb_q <= gen_resetb_d;
        end
    end

    assign tx_data    = (state_q == PRBS) ? gen_data : tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_hdr     = tx_hdr_q;
    assign tx_last    = tx_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_cnt   = byte_cnt_q;
    assign burst_cnt  = burst_cnt_q;
    assign gen_resetb = gen_resetb_q;

endmodule

// File: doc/prbs_burst_sequencer.md
PRBS_BURST_SEQUENCER -- requirements
Module: prbs_burst_sequencer

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hBC: header byte value sent before each burst.
REQ-002 SHALL have parameter HDR_LEN, default 4: header bytes per burst; legal range 2..255.
REQ-003 SHALL have parameter GAP_LEN, default 8: idle cycles between bursts in loop mode; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port resetb, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: begin a burst sequence; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: terminate the sequence immediately.
REQ-008 SHALL have port loop_en, input, 1: repeat bursts; sampled on the last PRBS byte of each burst.
REQ-009 SHALL have port burst_len, input, 16: PRBS bytes per burst; latched on an accepted start.
REQ-010 SHALL have port gen_data, input, 8: byte from the external PRBS15 byte generator.
REQ-011 SHALL have port gen_resetb, output, 1: registered active-low reset driven to the generator.
REQ-012 SHALL have ports tx_data (8), tx_valid (1), tx_hdr (1), tx_last (1), outputs: the transmitted stream.
REQ-013 SHALL have ports busy (1) and done (1), outputs: sequence active; one-cycle end-of-burst pulse.
REQ-014 SHALL have ports byte_cnt (16) and burst_cnt (16), outputs: PRBS bytes sent in the current burst; bursts completed.

Function
REQ-015 SHALL implement states IDLE, HEADER, PRBS and GAP.
REQ-016 IDLE: start=1, abort=0 and burst_len!=0 -> HEADER next cycle; latch burst_len; clear byte_cnt and burst_cnt; busy=1 from that cycle.
REQ-017 start with burst_len=0 SHALL be ignored: stay in IDLE, busy stays 0.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 HEADER SHALL last exactly HDR_LEN cycles: tx_valid=1, tx_hdr=1, tx_data=HDR_BYTE.
REQ-020 gen_resetb SHALL be 0 in IDLE, GAP and header cycles 1..HDR_LEN-1, and 1 from header cycle HDR_LEN through the last PRBS cycle.
REQ-021 PRBS SHALL last burst_len cycles: tx_valid=1, tx_hdr=0, tx_data=gen_data (combinational pass-through). The first byte SHALL be 8'h02, the generator seed.
REQ-022 byte_cnt SHALL increment on every PRBS cycle and hold its value after the burst ends; it cannot overflow because byte_cnt <= burst_len.
REQ-023 tx_last SHALL be 1 only on the final PRBS byte.
REQ-024 On the final PRBS byte, the following cycle SHALL have done=1 and burst_cnt+1 (wrapping at 16 bits).
REQ-025 In that following cycle: if loop_en was 1, state=GAP, else state=IDLE and busy=0 in the same cycle as the done pulse.
REQ-026 GAP SHALL last GAP_LEN cycles with tx_valid=0, then go to HEADER with byte_cnt cleared and the latched burst_len reused; the generator SHALL be reseeded, so each burst starts at 8'h02.
REQ-027 abort=1 in any state SHALL force IDLE next cycle with tx_valid=0, gen_resetb=0, busy=0 and no done pulse; byte_cnt and burst_cnt SHALL hold.
REQ-028 abort and start in the same cycle SHALL be resolved in favour of abort.
REQ-029 When tx_valid=0, tx_data, tx_hdr and tx_last SHALL be 0.

Reset
REQ-030 resetb=0 SHALL force IDLE and gen_resetb=0, and set tx_data, tx_valid, tx_hdr, tx_last, busy, done, byte_cnt and burst_cnt to 0 on the next edge.
REQ-031 resetb=0 mid-burst SHALL discard the sequence; there SHALL be no done pulse and outputs SHALL be 0 as in REQ-030.
REQ-032 After resetb release, the block SHALL need a new start to transmit.

Verification (HDR_LEN=4, GAP_LEN=8; bench compares PRBS bytes against a golden generator model seeded with 8'h02)
REQ-033 Reset: hold resetb=0 for 3 cycles -> all outputs 0, gen_resetb=0.
REQ-034 Single burst: start at cycle 0, burst_len=5, loop_en=0 -> response:
- cycles 1-4: tx_data=BC, tx_hdr=1;
- gen_resetb rises in cycle 4;
- cycles 5-9: PRBS bytes starting 02, matching the golden model;
- cycle 9: tx_last=1;
- cycle 10: done=1, busy=0, byte_cnt=5, burst_cnt=1.
REQ-035 Loop: burst_len=3, loop_en=1 -> response:
- 8 idle cycles after each burst, then header and 02 again;
- burst_cnt counts 1, 2, 3;
- drop loop_en during burst 3 -> IDLE after its done.
REQ-036 Abort on the 2nd PRBS byte of a burst_len=10 burst -> next cycle tx_valid=0, busy=0, gen_resetb=0; no done; byte_cnt=2.
REQ-037 Ignored and colliding commands -> response:
- start with burst_len=0 -> busy stays 0;
- start pulsed mid-burst -> no effect;
- abort+start in the same IDLE cycle -> stays IDLE.
REQ-038 resetb=0 during HEADER of a loop sequence -> all outputs 0 next cycle; no done; idle until a new start.
